// File: rtl/spm_pkg.sv
// spm_pkg: shared constants for the serial/parallel multiplier.
package spm_pkg;
  localparam int SPM_SIZE_DEF = 8;   // default multiplicand width
  localparam int SPM_SIZE_MAX = 32;  // widest supported multiplicand
endpackage

// File: rtl/spm_csa_cell.sv
// spm_csa_cell: one carry-save cell of the serial/parallel multiplier.
// Full adder of (partial product, upstream sum, own carry) with registered
// sum and carry. Optional hold input under macro SPM_ENABLE_EN.
module spm_csa_cell (
  input  logic clk,
  input  logic rst,
`ifdef SPM_ENABLE_EN
  input  logic en_i,
`endif
  input  logic a_i,     // partial-product bit x[i] & y
  input  logic s_in_i,  // sum from the next-higher cell
  output logic s_o      // registered sum toward the LSB
);
  logic s_q, s_d;
  logic c_q, c_d;
  logic adv;

`ifdef SPM_ENABLE_EN
  assign adv = en_i;
`else
  assign adv = 1'b1;
`endif

  // Full adder: carry stays in this cell, sum shifts one place toward p.
  always_comb begin
    s_d = a_i ^ s_in_i ^ c_q;
    c_d = (a_i & s_in_i) | (a_i & c_q) | (s_in_i & c_q);
  end

  // Sum/carry state; reset wins over hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= 1'b0;
      c_q <= 1'b0;
    end else if (adv) begin
      s_q <= s_d;
      c_q <= c_d;
    end
  end

  assign s_o = s_q;
endmodule

// File: rtl/spm.sv
// spm: bit-serial / parallel signed multiplier (carry-save array).
// x is held in parallel, y arrives LSB first, p leaves LSB first one
// clock later. Optional en input under macro SPM_ENABLE_EN.
module spm
  import spm_pkg::*;
#(
  parameter int size = SPM_SIZE_DEF
) (
  input  logic            clk,
  input  logic            rst,
`ifdef SPM_ENABLE_EN
  input  logic            en,
`endif
  input  logic [size-1:0] x,
  input  logic            y,
  output logic            p
);
  logic [size-1:0] s;      // registered sum of each cell
  logic [size-1:0] a;      // partial products
  logic            sgn_s_q, sgn_s_d;
  logic            sgn_c_q, sgn_c_d;
  logic            adv;

`ifdef SPM_ENABLE_EN
  assign adv = en;
`else
  assign adv = 1'b1;
`endif

  assign a = x & {size{y}};

  // Magnitude cells 0..size-2; each consumes the sum of the cell above it.
  for (genvar i = 0; i < size - 1; i++) begin : g_cell
    spm_csa_cell u_cell (
      .clk    (clk),
      .rst    (rst),
`ifdef SPM_ENABLE_EN
      .en_i   (en),
`endif
      .a_i    (a[i]),
      .s_in_i (s[i+1]),
      .s_o    (s[i])
    );
  end

  // Sign cell: serial two's complement of the x-MSB partial-product stream.
  // The carry flop records "a one has been seen": bits pass unchanged up to
  // and including the first one and are inverted afterwards, which equals
  // invert-plus-one and yields an endless sign-extension stream.
  always_comb begin
    sgn_s_d = a[size-1] ^ sgn_c_q;
    sgn_c_d = a[size-1] | sgn_c_q;
  end

  // Sign cell state; reset wins over hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      sgn_s_q <= 1'b0;
      sgn_c_q <= 1'b0;
    end else if (adv) begin
      sgn_s_q <= sgn_s_d;
      sgn_c_q <= sgn_c_d;
    end
  end

  assign s[size-1] = sgn_s_q;
  assign p         = s[0];
endmodule

// File: tb/tb_spm.sv
// tb_spm: directed, table-driven checks of the serial/parallel multiplier.
module tb_spm;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] x;
  logic       y;
  logic       p;
`ifdef SPM_ENABLE_EN
  logic       en;
`endif

  int checks   = 0;
  int failures = 0;

  spm #(.size(8)) dut (
    .clk (clk),
    .rst (rst),
`ifdef SPM_ENABLE_EN
    .en  (en),
`endif
    .x   (x),
    .y   (y),
    .p   (p)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [7:0]  xv;
    logic [23:0] ys;   // serial y stream, bit k applied in cycle k
    logic [23:0] exp;  // 24-bit two's-complement product
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    y   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic run(input logic [7:0] xv, input logic [23:0] ys, output logic [23:0] got);
    x = xv;
    for (int k = 0; k < 24; k++) begin
      y = ys[k];
      tick();
      got[k] = p;
    end
    y = 1'b0;
  endtask

  initial begin
    logic [23:0] got;
    logic        zero_ok;

    rst = 1'b1;
    x   = 8'd0;
    y   = 1'b0;
`ifdef SPM_ENABLE_EN
    en  = 1'b1;
`endif

    vecs[0] = '{"50x50",     8'd50,  24'd50,     24'h0009C4};
    vecs[1] = '{"25x65",     8'd25,  24'd65,     24'h000659};
    vecs[2] = '{"80x9",      8'd80,  24'd9,      24'h0002D0};
    vecs[3] = '{"9x80",      8'd9,   24'd80,     24'h0002D0};
    vecs[4] = '{"m9x80",     8'hF7,  24'd80,     24'hFFFD30};
    vecs[5] = '{"m8x80",     8'hF8,  24'd80,     24'hFFFD80};
    vecs[6] = '{"m9xm80sx",  8'hF7,  24'hFFFFB0, 24'h0002D0};

    // Reset: p low during and after a 2-cycle pulse, idle stream stays zero.
    tick();
    check("rst_p_during", {31'd0, p}, 32'd0);
    tick();
    rst = 1'b0;
    check("rst_p_after", {31'd0, p}, 32'd0);
    x = 8'hFF;
    zero_ok = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (p !== 1'b0) zero_ok = 1'b0;
    end
    check("idle_y0_p0", {31'd0, zero_ok}, 32'd1);

    // Table-driven products, fresh reset before each.
    foreach (vecs[i]) begin
      do_reset();
      run(vecs[i].xv, vecs[i].ys, got);
      check(vecs[i].name, {8'd0, got}, {8'd0, vecs[i].exp});
    end

    // Longer capture of a negative product: upper bits all ones.
    do_reset();
    x = 8'hF8;
    got = '0;
    for (int k = 0; k < 32; k++) begin
      y = (k < 8) ? ((8'd80 >> k) & 8'd1) != 0 : 1'b0;
      tick();
      if (k >= 16 && k < 32) got[k-16] = p;
    end
    y = 1'b0;
    check("sext_hi16", {16'd0, got[15:0]}, 32'h0000FFFF);

    // Abort mid-stream, then a fresh multiply.
    do_reset();
    x = 8'hF7;
    for (int k = 0; k < 5; k++) begin
      y = ((8'd80 >> k) & 8'd1) != 0;
      tick();
    end
    rst = 1'b1;
    y   = 1'b1;
    tick();
    check("midrst_p0", {31'd0, p}, 32'd0);
    rst = 1'b0;
    run(8'd3, 24'd5, got);
    check("after_abort_3x5", {8'd0, got}, 32'd15);

`ifdef SPM_ENABLE_EN
    // en toggling: enabled cycles alone produce 2500, p frozen when en=0.
    begin
      logic hold_ok;
      logic last;
      do_reset();
      x = 8'd50;
      hold_ok = 1'b1;
      got = '0;
      for (int k = 0; k < 24; k++) begin
        en = 1'b1;
        y  = k < 8 ? ((8'd50 >> k) & 8'd1) != 0 : 1'b0;
        tick();
        got[k] = p;
        last = p;
        en = 1'b0;
        y  = 1'($urandom_range(0, 1));
        tick();
        if (p !== last) hold_ok = 1'b0;
      end
      en = 1'b1;
      y  = 1'b0;
      check("en_50x50", {8'd0, got}, 32'h000009C4);
      check("en_hold", {31'd0, hold_ok}, 32'd1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
